// File: rtl/simon_key_expander.sv
// simon_key_expander: handshaked SIMON key schedule, one round key per accepted transfer.
// Define SIMON_KEY_REVERSE_EN to add reverse-order (decryption) delivery through an internal key buffer.
module simon_key_expander #(
  parameter int WORD_SIZE = 16,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 32,
  parameter int CONST_SEQ = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [KEY_WORDS*WORD_SIZE-1:0] key_in,
  output logic                           ready,
  output logic                           key_valid,
  input  logic                           key_ready,
`ifdef SIMON_KEY_REVERSE_EN
  input  logic                           decrypt,
`endif
  output logic [WORD_SIZE-1:0]           key_out,
  output logic [6:0]                     round_idx,
  output logic                           key_last
);

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);
  localparam logic [WORD_SIZE-1:0] RC = ~WORD_SIZE'(3);

  // Leftmost character of each published z string sits in bit 61.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] ZSEQ = (CONST_SEQ == 0) ? Z0 :
                                 (CONST_SEQ == 1) ? Z1 :
                                 (CONST_SEQ == 2) ? Z2 :
                                 (CONST_SEQ == 3) ? Z3 : Z4;

  function automatic logic [WORD_SIZE-1:0] ror(input logic [WORD_SIZE-1:0] x, input int r);
    return (x >> r) | (x << (WORD_SIZE - r));
  endfunction

  function automatic logic zbit(input logic [5:0] ptr);
    return ZSEQ[6'd61 - ptr];
  endfunction

  function automatic logic [WORD_SIZE-1:0] next_word(
    input logic [WORD_SIZE-1:0] oldest,
    input logic [WORD_SIZE-1:0] newest,
    input logic [WORD_SIZE-1:0] second,
    input logic                 z
  );
    logic [WORD_SIZE-1:0] t;
    t = ror(newest, 3) ^ ((KEY_WORDS == 4) ? second : '0);
    return oldest ^ t ^ ror(t, 1) ^ RC ^ WORD_SIZE'(z);
  endfunction

`ifdef SIMON_KEY_REVERSE_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FILL, S_DRAIN} state_t;
  localparam int BI = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t               state;
  logic [WORD_SIZE-1:0] w [KEY_WORDS];
  logic [5:0]           zptr;
  logic [WORD_SIZE-1:0] new_word;
  logic                 xfer;

  assign xfer     = key_valid & key_ready;
  assign ready    = (state == S_IDLE);
  assign new_word = next_word(w[0], w[KEY_WORDS-1], w[1], zbit(zptr));

  // Window shifts one word per generated key; w[0] is always the key at round_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      key_valid <= 1'b0;
      round_idx <= 7'd0;
      zptr      <= 6'd0;
      for (int i = 0; i < KEY_WORDS; i++) w[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < KEY_WORDS; i++) w[i] <= key_in[i*WORD_SIZE +: WORD_SIZE];
            round_idx <= 7'd0;
            zptr      <= 6'd0;
`ifdef SIMON_KEY_REVERSE_EN
            if (decrypt) begin
              state     <= S_FILL;
              key_valid <= 1'b0;
            end else begin
              state     <= S_RUN;
              key_valid <= 1'b1;
            end
`else
            state     <= S_RUN;
            key_valid <= 1'b1;
`endif
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (round_idx == LAST_IDX) begin
              state     <= S_IDLE;
              key_valid <= 1'b0;
            end else begin
              for (int i = 0; i < KEY_WORDS - 1; i++) w[i] <= w[i+1];
              w[KEY_WORDS-1] <= new_word;
              round_idx      <= round_idx + 7'd1;
              zptr           <= (zptr == 6'd61) ? 6'd0 : zptr + 6'd1;
            end
          end
        end
`ifdef SIMON_KEY_REVERSE_EN
        S_FILL: begin
          if (round_idx == LAST_IDX) begin
            state     <= S_DRAIN;
            key_valid <= 1'b1;
          end else begin
            for (int i = 0; i < KEY_WORDS - 1; i++) w[i] <= w[i+1];
            w[KEY_WORDS-1] <= new_word;
            round_idx      <= round_idx + 7'd1;
            zptr           <= (zptr == 6'd61) ? 6'd0 : zptr + 6'd1;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            if (round_idx == 7'd0) begin
              state     <= S_IDLE;
              key_valid <= 1'b0;
            end else begin
              round_idx <= round_idx - 7'd1;
            end
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          key_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SIMON_KEY_REVERSE_EN
  logic [WORD_SIZE-1:0] key_buf [ROUNDS];
  logic [WORD_SIZE-1:0] drain_word;
  logic [BI-1:0]        bidx;

  assign bidx = round_idx[BI-1:0];

  // Buffer captures every generated key; drain_word is the registered read for reverse delivery.
  always_ff @(posedge clk) begin
    if ((state == S_RUN && xfer) || state == S_FILL) key_buf[bidx] <= w[0];
    if (state == S_FILL && round_idx == LAST_IDX) drain_word <= w[0];
    else if (state == S_DRAIN && xfer && round_idx != 7'd0) drain_word <= key_buf[bidx - BI'(1)];
  end

  assign key_out  = (state == S_DRAIN) ? drain_word : w[0];
  assign key_last = key_valid & ((state == S_DRAIN) ? (round_idx == 7'd0) : (round_idx == LAST_IDX));
`else
  assign key_out  = w[0];
  assign key_last = key_valid & (round_idx == LAST_IDX);
`endif

endmodule
